// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch queue.
package if_fetch_queue_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [CPU_WIDTH-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Synchronous FIFO with push/pop/clear, occupancy count and combinational head output.
module if_fetch_queue_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= wdata;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues ROM reads against credit, tracks the in-flight response and buffers
// {instruction, pc} pairs for decode; redirect flushes everything in one cycle.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_STEP = if_fetch_queue_pkg::PC_STEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena_i,
  input  logic [CPU_WIDTH-1:0] curr_pc_i,
  output logic [CPU_WIDTH-1:0] next_pc_o,
  input  logic                 redirect_i,
  input  logic [CPU_WIDTH-1:0] redirect_pc_i,
  output logic                 imem_en_o,
  output logic [CPU_WIDTH-1:0] imem_addr_o,
  input  logic [CPU_WIDTH-1:0] imem_rdata_i,
  output logic                 inst_valid_o,
  output logic [CPU_WIDTH-1:0] inst_o,
  output logic [CPU_WIDTH-1:0] inst_pc_o,
  input  logic                 dec_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [CPU_WIDTH-1:0] PcInc = CPU_WIDTH'(PC_STEP);
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  logic                   inflight_q;
  logic [CPU_WIDTH-1:0]   pc_q;
  logic [CntW-1:0]        count;
  logic [2*CPU_WIDTH-1:0] head;
  logic                   pop, push, issue;
  logic [OccW-1:0]        occupancy;

  assign pop = inst_valid_o & dec_ready_i;

  // Entries left after this cycle's pop plus the outstanding response must fit.
  assign occupancy = OccW'(count) - OccW'(pop) + OccW'(inflight_q);
  assign issue     = rst_n & ena_i & ~redirect_i & (occupancy < DepthOcc);

  // Redirect kills the response arriving this cycle.
  assign push = inflight_q & ~redirect_i;

  always_comb begin
    next_pc_o = curr_pc_i;
    if (rst_n) begin
      if (redirect_i) begin
        next_pc_o = redirect_pc_i;
      end else if (issue) begin
        next_pc_o = curr_pc_i + PcInc;
      end
    end
  end

  assign imem_en_o   = issue;
  assign imem_addr_o = curr_pc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q <= curr_pc_i;
      end
    end
  end

  if_fetch_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * CPU_WIDTH),
    .CNT_W (CntW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (redirect_i),
    .wdata     ({imem_rdata_i, pc_q}),
    .rdata     (head),
    .count     (count),
    .not_empty (inst_valid_o)
  );

  assign inst_o    = head[2*CPU_WIDTH-1:CPU_WIDTH];
  assign inst_pc_o = head[CPU_WIDTH-1:0];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: closed PC loop, ROM model and a queue-based reference model.
module tb_if_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena_i;
  logic [31:0] curr_pc_i;
  logic [31:0] next_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        dec_ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl;
  logic [31:0] m_ipc;

  if_fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena_i         (ena_i),
    .curr_pc_i     (curr_pc_i),
    .next_pc_o     (next_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .dec_ready_i   (dec_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check DUT against the model, clock, advance model and the PC loop.
  task automatic step();
    bit          e_valid, e_pop, e_issue;
    logic [31:0] e_npc, s_npc, s_addr;
    bit          s_en;
    ent_t        e;
    #2;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && dec_ready_i;
    e_issue = ena_i && !redirect_i && ((int'(mq.size()) - int'(e_pop) + int'(m_infl)) < DEPTH);
    e_npc   = redirect_i ? redirect_pc_i : (e_issue ? curr_pc_i + 32'd4 : curr_pc_i);
    chk("imem_en", {31'b0, imem_en_o}, {31'b0, e_issue});
    chk("next_pc", next_pc_o, e_npc);
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
    if (e_issue) chk("imem_addr", imem_addr_o, curr_pc_i);
    if (e_valid) begin
      chk("inst_pc", inst_pc_o, mq[0].pc);
      chk("inst", inst_o, mq[0].ins);
    end
    s_en   = imem_en_o;
    s_addr = imem_addr_o;
    s_npc  = next_pc_o;
    @(posedge clk);
    if (redirect_i) begin
      mq.delete();
      m_infl = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl) begin
        e.pc  = m_ipc;
        e.ins = rom(m_ipc);
        mq.push_back(e);
      end
      m_infl = e_issue;
      if (e_issue) m_ipc = curr_pc_i;
    end
    #1;
    curr_pc_i    = s_npc;
    imem_rdata_i = s_en ? rom(s_addr) : $urandom;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n         = 1'b0;
    ena_i         = 1'b0;
    curr_pc_i     = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rdata_i  = 32'h0;
    dec_ready_i   = 1'b1;
    m_infl        = 0;
    m_ipc         = 32'h0;
    #2;
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    ena_i = 1'b1;
    #1;
    chk("rst_imem_en", {31'b0, imem_en_o}, 32'd0);
    chk("rst_next_pc", next_pc_o, curr_pc_i);
    ena_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle, then back-to-back fetch with decode always ready.
    steps(2);
    ena_i = 1'b1;
    steps(4);

    // Decode stall fills the FIFO, then drains.
    dec_ready_i = 1'b0;
    steps(5);
    chk("stall_full", {31'b0, inst_valid_o}, 32'd1);
    dec_ready_i = 1'b1;
    steps(6);

    // Redirect mid-stream.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    steps(5);

    // Redirect with pop and push in the same cycle (steady state).
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    chk("redir_empty", {31'b0, inst_valid_o}, 32'd0);
    steps(4);

    // PC wrap at the top of the address space.
    curr_pc_i = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc", curr_pc_i, 32'h0);
    steps(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ena_i         = ($urandom_range(3) != 0);
      dec_ready_i   = ($urandom_range(9) < 7);
      redirect_i    = ($urandom_range(19) == 0);
      redirect_pc_i = $urandom & 32'hFFFF_FFFC;
      step();
    end
    redirect_i = 1'b0;

    // Asynchronous reset with a full FIFO.
    ena_i       = 1'b1;
    dec_ready_i = 1'b0;
    steps(5);
    chk("pre_rst_full", {31'b0, inst_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("async_imem_en", {31'b0, imem_en_o}, 32'd0);
    chk("async_next_pc", next_pc_o, curr_pc_i);
    mq.delete();
    m_infl = 0;
    @(posedge clk);
    #1;
    curr_pc_i   = 32'h0;
    rst_n       = 1'b1;
    dec_ready_i = 1'b1;
    steps(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1);
  end

endmodule
